// File: rtl/noobs_assert_pkg.sv
// rtl/noobs_assert_pkg.sv - shared state encoding, counter widths and helpers for the assertion event log
package noobs_assert_pkg;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_TRIPPED  = 2'd2
   } log_state_t;

   localparam int DROP_CNT_W = 8;

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/assert_evt_fifo.sv
// rtl/assert_evt_fifo.sv - event FIFO with flush; head reads as zero while empty
module assert_evt_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/assert_event_log.sv
// rtl/assert_event_log.sv - timestamped violation event logger; ASSERT_LOG_HALT_EN builds the halt request
module assert_event_log
   import noobs_assert_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int DEPTH   = 8,
   parameter int TS_W    = 16
) (
   input  logic                  clk,
   input  logic                  reset_,
   input  logic                  arm,
   input  logic                  clear,
   input  logic [NUM_SRC-1:0]    viol,
   output logic                  evt_valid,
   input  logic                  evt_ready,
   output logic [NUM_SRC-1:0]    evt_mask,
   output logic [TS_W-1:0]       evt_ts,
   output logic [3:0]            first_src,
   output logic                  tripped,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   output logic                  halt_req
);

   localparam int EW = NUM_SRC + TS_W;

   logic [TS_W-1:0]    ts_cnt;
   logic [NUM_SRC-1:0] viol_q;
   logic [NUM_SRC-1:0] rise;
   logic [15:0]        rise_ext;
   logic               primed;
   log_state_t         state;
   log_state_t         state_nxt;
   logic               push_req;
   logic               pop;
   logic               push_ok;
   logic               drop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [EW-1:0]      head;

   // viol_q holds no real history until the first edge after reset.
   assign rise     = primed ? (viol & ~viol_q) : '0;
   assign push_req = arm && (rise != '0) && !clear;
   assign pop      = evt_ready && !fifo_empty && !clear;
   assign push_ok  = push_req && (!fifo_full || pop);
   assign drop     = push_req && fifo_full && !pop;

   always_comb begin
      rise_ext = '0;
      rise_ext[NUM_SRC-1:0] = rise;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         ts_cnt <= '0;
         viol_q <= '0;
         primed <= 1'b0;
      end else begin
         ts_cnt <= ts_cnt + TS_W'(1);
         viol_q <= viol;
         primed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) state <= ST_DISARMED;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = arm ? ST_ARMED : ST_DISARMED;
      end else if (!arm) begin
         state_nxt = ST_DISARMED;
      end else begin
         case (state)
            ST_DISARMED: state_nxt = ST_ARMED;
            ST_ARMED:    if (push_ok) state_nxt = ST_TRIPPED;
            ST_TRIPPED:  state_nxt = ST_TRIPPED;
            default:     state_nxt = ST_DISARMED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         tripped   <= 1'b0;
         first_src <= '0;
         overflow  <= 1'b0;
         drop_cnt  <= '0;
      end else if (clear) begin
         tripped   <= 1'b0;
         first_src <= '0;
         overflow  <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         if (state == ST_ARMED && state_nxt == ST_TRIPPED) begin
            tripped   <= 1'b1;
            first_src <= lowest_set(rise_ext);
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
         end
      end
   end

   assert_evt_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset_(reset_),
      .flush (clear),
      .push  (push_ok),
      .din   ({rise, ts_cnt}),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign evt_valid = !fifo_empty;
   assign evt_mask  = head[EW-1:TS_W];
   assign evt_ts    = head[TS_W-1:0];

`ifdef ASSERT_LOG_HALT_EN
   logic halt_q;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) halt_q <= 1'b0;
      else         halt_q <= (state_nxt == ST_TRIPPED);
   end

   assign halt_req = halt_q;
`else
   assign halt_req = 1'b0;
`endif

endmodule

// File: tb/tb_assert_event_log.sv
// tb/tb_assert_event_log.sv - directed self-checking bench for assert_event_log
module tb_assert_event_log;

`ifdef ASSERT_LOG_HALT_EN
   localparam logic HALT_EXP = 1'b1;
`else
   localparam logic HALT_EXP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_ = 1'b0;
   logic        arm = 1'b0;
   logic        clear = 1'b0;
   logic [7:0]  viol = '0;
   logic        evt_valid;
   logic        evt_ready = 1'b0;
   logic [7:0]  evt_mask;
   logic [15:0] evt_ts;
   logic [3:0]  first_src;
   logic        tripped;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        halt_req;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] model_ts;
   logic [15:0] e0;
   logic [7:0]  last_mask;
   int          n;

   assert_event_log dut (
      .clk      (clk),
      .reset_   (reset_),
      .arm      (arm),
      .clear    (clear),
      .viol     (viol),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .evt_mask (evt_mask),
      .evt_ts   (evt_ts),
      .first_src(first_src),
      .tripped  (tripped),
      .overflow (overflow),
      .drop_cnt (drop_cnt),
      .halt_req (halt_req)
   );

   always #5 clk = ~clk;

   // Reference timestamp: the value the DUT counter holds between edges.
   always @(posedge clk or negedge reset_) begin
      if (!reset_) model_ts <= '0;
      else         model_ts <= model_ts + 16'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic wait_ts(input logic [15:0] t);
      for (int k = 0; k < 200 && model_ts != t; k++) tick();
      check("wait_ts", model_ts, t);
   endtask

   initial begin
      tick(); tick(); tick();
      check("rst_valid", evt_valid, 0);
      check("rst_mask", evt_mask, 0);
      check("rst_ts", evt_ts, 0);
      check("rst_tripped", tripped, 0);
      check("rst_first", first_src, 0);
      check("rst_ovf", overflow, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_halt", halt_req, 0);
      reset_ = 1'b1;
      tick();
      arm = 1'b1;
      tick(); tick();

      // single held rise at ts=10
      wait_ts(16'd10);
      viol = 8'h08;
      #0;
      check("no_bypass", evt_valid, 0);
      tick();
      check("r35_valid", evt_valid, 1);
      check("r35_mask", evt_mask, 8'h08);
      check("r35_ts", evt_ts, 16'd10);
      check("r35_tripped", tripped, 1);
      check("r35_first", first_src, 3);
      check("r35_halt", halt_req, HALT_EXP);
      tick(); tick(); tick(); tick();
      check("r35_stable", evt_mask, 8'h08);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check("r35_one_entry", evt_valid, 0);
      viol = 8'h00;

      // simultaneous rises merge
      pulse_clear();
      check("clr_tripped", tripped, 0);
      check("clr_halt", halt_req, 0);
      viol = 8'h22;
      e0 = model_ts;
      tick();
      viol = 8'h00;
      check("r36_mask", evt_mask, 8'h22);
      check("r36_ts", evt_ts, e0);
      check("r36_first", first_src, 1);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;

      // full FIFO with pop and push in the same cycle
      pulse_clear();
      e0 = model_ts;
      for (int i = 0; i < 8; i++) begin
         viol = 8'(1 << i);
         tick();
      end
      evt_ready = 1'b1;
      viol = 8'h01;
      tick();
      evt_ready = 1'b0;
      check("r38_ovf", overflow, 0);
      check("r38_drop", drop_cnt, 0);
      check("r38_head", evt_mask, 8'h02);
      check("r38_head_ts", evt_ts, e0 + 16'd1);
      evt_ready = 1'b1;
      n = 0;
      last_mask = '0;
      for (int k = 0; k < 20 && evt_valid; k++) begin
         last_mask = evt_mask;
         n++;
         tick();
      end
      evt_ready = 1'b0;
      viol = 8'h00;
      check("r38_count", n, 8);
      check("r38_last", last_mask, 8'h01);

      // overflow: 10 rises into 8 entries
      pulse_clear();
      e0 = model_ts;
      for (int i = 0; i < 10; i++) begin
         viol = 8'(1 << (i % 8));
         tick();
      end
      viol = 8'h00;
      tick();
      check("r37_valid", evt_valid, 1);
      check("r37_head", evt_mask, 8'h01);
      check("r37_head_ts", evt_ts, e0);
      check("r37_ovf", overflow, 1);
      check("r37_drop", drop_cnt, 2);
      evt_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 20 && evt_valid; k++) begin
         check("r37_entry_mask", evt_mask, 32'(1 << k));
         check("r37_entry_ts", evt_ts, e0 + 16'(k));
         n++;
         tick();
      end
      evt_ready = 1'b0;
      check("r37_count", n, 8);
      check("r37_ovf_sticky", overflow, 1);

      // clear with 3 entries queued
      for (int i = 0; i < 3; i++) begin
         viol = 8'(1 << i);
         tick();
      end
      viol = 8'h00;
      tick();
      check("r39_pre_valid", evt_valid, 1);
      pulse_clear();
      check("r39_valid", evt_valid, 0);
      check("r39_tripped", tripped, 0);
      check("r39_ovf", overflow, 0);
      check("r39_drop", drop_cnt, 0);
      check("r39_first", first_src, 0);
      check("r39_state", 32'(dut.state), 1);
      viol = 8'h10;
      tick();
      viol = 8'h00;
      check("r39_relog", evt_mask, 8'h10);
      check("r39_retrip", tripped, 1);
      check("r39_refirst", first_src, 4);

      // level already high when arming is not logged
      arm = 1'b0;
      pulse_clear();
      viol = 8'h04;
      tick(); tick();
      check("disarm_nolog", evt_valid, 0);
      arm = 1'b1;
      tick(); tick();
      check("arm_held_nolog", evt_valid, 0);
      viol = 8'h00;
      tick();
      viol = 8'h04;
      tick();
      viol = 8'h00;
      check("arm_rise_log", evt_mask, 8'h04);

      // asynchronous reset mid-read
      pulse_clear();
      for (int i = 0; i < 4; i++) begin
         viol = 8'(1 << i);
         tick();
      end
      viol = 8'h00;
      evt_ready = 1'b1;
      tick();
      check("r40_mid_head", evt_mask, 8'h02);
      #2;
      reset_ = 1'b0;
      #1;
      check("r40_valid", evt_valid, 0);
      check("r40_mask", evt_mask, 0);
      check("r40_ts", evt_ts, 0);
      check("r40_tripped", tripped, 0);
      check("r40_first", first_src, 0);
      check("r40_halt", halt_req, 0);
      evt_ready = 1'b0;
      tick();
      reset_ = 1'b1;
      tick();
      check("r40_post_valid", evt_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
